// File: rtl/demap_pkg.sv
// Shared constants and FSM encoding for the demapper receive path.
package demap_pkg;

  localparam logic [7:0] FasByte0 = 8'hF6;
  localparam logic [7:0] FasByte1 = 8'h28;

  // FAS occupies (FasRow, FasCol) and (FasRow, FasCol + 1).
  localparam int unsigned FasRow = 0;
  localparam int unsigned FasCol = 0;

  localparam int unsigned OhRow = 0;
  localparam int unsigned OhCol = 2;

  // The CRC byte sits this many rows/cols back from the frame end: (ROWS-1, COLS-1).
  localparam int unsigned CrcRowOff = 1;
  localparam int unsigned CrcColOff = 1;

  localparam logic [7:0] CrcPoly = 8'h07;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StSync   = 2'd2
  } demap_state_e;

endpackage

// File: rtl/demapper_rx_crc8_step.sv
// Combinational CRC-8 update (poly 0x07, MSB-first) for one data byte.
module crc8_step
  import demap_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_c;

  always_comb begin
    crc_c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      crc_c = crc_c[7] ? ((crc_c << 1) ^ CrcPoly) : (crc_c << 1);
    end
    crc_o = crc_c;
  end

endmodule

// File: rtl/demapper_rx.sv
// Receive demapper: FAS hunt/verify/sync, overhead + payload extraction, per-frame CRC-8 check.
// Define DEMAP_ARQ_EN to drive o_retrans_req on CRC errors and on loss of frame.
module demapper_rx
  import demap_pkg::*;
#(
  parameter int unsigned COLS       = 1024,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned LOF_THRESH = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  output logic       o_pyld_last,
  output logic [7:0] o_frame_seq,
  output logic       o_in_frame,
  output logic       o_crc_err,
  output logic       o_crc_err_valid,
  output logic       o_retrans_req,
  output logic [7:0] o_crc_val
);

  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned MissW = (LOF_THRESH > 1) ? $clog2(LOF_THRESH) : 1;

  localparam logic [ColW-1:0]  LastCol  = ColW'(COLS - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(ROWS - 1);
  localparam logic [ColW-1:0]  CrcCol   = ColW'(COLS - CrcColOff);
  localparam logic [RowW-1:0]  CrcRow   = RowW'(ROWS - CrcRowOff);
  localparam logic [ColW-1:0]  LastPcol = ColW'(COLS - CrcColOff - 1);
  localparam logic [MissW-1:0] LofLast  = MissW'(LOF_THRESH - 1);

`ifdef DEMAP_ARQ_EN
  localparam bit ArqEn = 1'b1;
`else
  localparam bit ArqEn = 1'b0;
`endif

  demap_state_e    state_q;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [MissW-1:0] miss_q;
  logic            fas_pend_q;
  logic            fas0_bad_q;
  logic [7:0]      crc_q, crc_d;

  logic [7:0]      pyld_data_q;
  logic            pyld_valid_q, pyld_last_q;
  logic [7:0]      frame_seq_q;
  logic            in_frame_q;
  logic            crc_err_q, crc_err_valid_q;
  logic            retrans_q;
  logic [7:0]      crc_val_q;

  logic at_fas0, at_fas1, at_oh, at_crc, at_last_pyld;
  logic fas0_ok, fas1_ok, crc_bad;

  crc8_step u_crc8_step (
    .crc_i  (crc_q),
    .data_i (i_frame_data),
    .crc_o  (crc_d)
  );

  always_comb begin
    at_fas0      = (row_q == RowW'(FasRow)) && (col_q == ColW'(FasCol));
    at_fas1      = (row_q == RowW'(FasRow)) && (col_q == ColW'(FasCol + 1));
    at_oh        = (row_q == RowW'(OhRow)) && (col_q == ColW'(OhCol));
    at_crc       = (row_q == CrcRow) && (col_q == CrcCol);
    at_last_pyld = (row_q == CrcRow) && (col_q == LastPcol);
    fas0_ok      = (i_frame_data == FasByte0);
    fas1_ok      = (i_frame_data == FasByte1);
    crc_bad      = (crc_q != i_frame_data);

    row_d = row_q;
    col_d = col_q + 1'b1;
    if (col_q == LastCol) begin
      col_d = '0;
      row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= StHunt;
      row_q           <= '0;
      col_q           <= '0;
      miss_q          <= '0;
      fas_pend_q      <= 1'b0;
      fas0_bad_q      <= 1'b0;
      crc_q           <= '0;
      pyld_data_q     <= '0;
      pyld_valid_q    <= 1'b0;
      pyld_last_q     <= 1'b0;
      frame_seq_q     <= '0;
      in_frame_q      <= 1'b0;
      crc_err_q       <= 1'b0;
      crc_err_valid_q <= 1'b0;
      retrans_q       <= 1'b0;
      crc_val_q       <= '0;
    end else begin
      pyld_valid_q    <= 1'b0;
      pyld_last_q     <= 1'b0;
      crc_err_valid_q <= 1'b0;
      retrans_q       <= 1'b0;
      if (i_frame_data_valid) begin
        unique case (state_q)
          StHunt: begin
            if (fas_pend_q && fas1_ok) begin
              // The byte after the FAS is the overhead position.
              state_q    <= StVerify;
              row_q      <= RowW'(OhRow);
              col_q      <= ColW'(OhCol);
              fas_pend_q <= 1'b0;
            end else begin
              fas_pend_q <= fas0_ok;
            end
          end
          StVerify: begin
            row_q <= row_d;
            col_q <= col_d;
            if (at_fas0 && !fas0_ok) begin
              state_q    <= StHunt;
              fas_pend_q <= 1'b0;
            end else if (at_fas1) begin
              if (!fas1_ok) begin
                state_q    <= StHunt;
                fas_pend_q <= fas0_ok;
              end else begin
                state_q    <= StSync;
                in_frame_q <= 1'b1;
                miss_q     <= '0;
                crc_q      <= '0;
              end
            end
          end
          StSync: begin
            row_q <= row_d;
            col_q <= col_d;
            if (at_fas0) begin
              fas0_bad_q <= !fas0_ok;
            end else if (at_fas1) begin
              if (fas0_bad_q || !fas1_ok) begin
                if (miss_q == LofLast) begin
                  state_q    <= StHunt;
                  in_frame_q <= 1'b0;
                  miss_q     <= '0;
                  fas_pend_q <= fas0_ok;
                  retrans_q  <= ArqEn;
                end else begin
                  miss_q <= miss_q + 1'b1;
                end
              end else begin
                miss_q <= '0;
              end
            end else if (at_crc) begin
              crc_err_valid_q <= 1'b1;
              crc_err_q       <= crc_bad;
              crc_val_q       <= i_frame_data;
              retrans_q       <= ArqEn & crc_bad;
              crc_q           <= '0;
            end else begin
              crc_q <= crc_d;
              if (at_oh) begin
                frame_seq_q <= i_frame_data;
              end else begin
                pyld_valid_q <= 1'b1;
                pyld_data_q  <= i_frame_data;
                pyld_last_q  <= at_last_pyld;
              end
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign o_pyld_data       = pyld_data_q;
  assign o_pyld_data_valid = pyld_valid_q;
  assign o_pyld_last       = pyld_last_q;
  assign o_frame_seq       = frame_seq_q;
  assign o_in_frame        = in_frame_q;
  assign o_crc_err         = crc_err_q;
  assign o_crc_err_valid   = crc_err_valid_q;
  assign o_retrans_req     = retrans_q;
  assign o_crc_val         = crc_val_q;

endmodule
